// File: rtl/tmds_decoder_mc_pkg.sv
// Shared definitions for the multi-channel TMDS decoder: tracking states,
// control tokens, status bit positions and a symbol popcount helper.
package tmds_pkg;

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_BLANK,
    ST_LINE
  } trk_state_e;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  localparam int unsigned STAT_DE    = 0;
  localparam int unsigned STAT_LINE  = 1;
  localparam int unsigned STAT_FRAME = 2;

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_decoder_mc_sym_decode.sv
// Combinational single-channel TMDS symbol decoder: control tokens yield
// {c1,c0} with de=0, everything else is decoded as a data byte.
module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic       de,
  output logic       c1,
  output logic       c0,
  output logic       err
);

  logic [7:0] d;
  logic [3:0] pc;

  always_comb begin
    data = '0;
    de   = 1'b0;
    c1   = 1'b0;
    c0   = 1'b0;
    err  = 1'b0;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    pc   = popcount10(sym);
    case (sym)
      TOK_C00: {c1, c0} = 2'b00;
      TOK_C01: {c1, c0} = 2'b01;
      TOK_C10: {c1, c0} = 2'b10;
      TOK_C11: {c1, c0} = 2'b11;
      default: begin
        de      = 1'b1;
        data[0] = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
          data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        err = (pc < 4'd3) || (pc > 4'd7);
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder_mc.sv
// Multi-channel TMDS decoder: stage 1 decodes each channel, stage 2 checks
// channel agreement, tracks frame geometry and drives the pixel outputs.
module tmds_decoder_mc
  import tmds_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 600
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH*10-1:0]           sym_in,
  input  logic                        sym_vld,
  input  logic                        err_clr,
  output logic [NCH*8-1:0]            pix_data,
  output logic                        pix_de,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        pix_vld,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic [NCH-1:0]              sym_err,
  output logic                        frame_done,
  output logic [2:0]                  status
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int LW = $clog2(V_ACTIVE + 2);
  localparam int OW = 16;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] L_FULL = LW'(V_ACTIVE);
  localparam logic [LW-1:0] L_MAX  = LW'(V_ACTIVE + 1);

  logic [NCH*8-1:0] dec_data;
  logic [NCH-1:0]   dec_de, dec_c1, dec_c0, dec_err;
  logic             unused_ctl;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tmds_sym_decode u_dec (
      .sym  (sym_in[10*k +: 10]),
      .data (dec_data[8*k +: 8]),
      .de   (dec_de[k]),
      .c1   (dec_c1[k]),
      .c0   (dec_c0[k]),
      .err  (dec_err[k])
    );
  end

  // Only channel 0 carries sync; the other channels' control bits are dropped.
  assign unused_ctl = ^{dec_c1, dec_c0};

  logic             s1_vld, s1_c1, s1_c0;
  logic [NCH*8-1:0] s1_data;
  logic [NCH-1:0]   s1_de, s1_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_de   <= '0;
      s1_err  <= '0;
      s1_c1   <= 1'b0;
      s1_c0   <= 1'b0;
    end else begin
      s1_vld <= sym_vld;
      if (sym_vld) begin
        s1_data <= dec_data;
        s1_de   <= dec_de;
        s1_err  <= dec_err;
        s1_c1   <= dec_c1[0];
        s1_c0   <= dec_c0[0];
      end
    end
  end

  trk_state_e    state, state_n;
  logic [XW-1:0] x_cnt, x_n;
  logic [OW-1:0] ovf_cnt, ovf_n;
  logic [YW-1:0] y_cnt, y_n;
  logic [LW-1:0] lines, lines_n;
  logic          frame_bad, frame_bad_n;
  logic          done_n;
  logic [2:0]    new_err;
  logic          vs_rise, de_rise, de_fall;

  // pix_de/vsync only load on valid cycles, so they double as edge history.
  assign vs_rise = s1_c1 & ~vsync;
  assign de_rise = s1_de[0] & ~pix_de;
  assign de_fall = ~s1_de[0] & pix_de;

  always_comb begin
    state_n     = state;
    x_n         = x_cnt;
    ovf_n       = ovf_cnt;
    y_n         = y_cnt;
    lines_n     = lines;
    frame_bad_n = frame_bad;
    done_n      = 1'b0;
    new_err     = '0;
    if (s1_vld) begin
      new_err[STAT_DE] = (s1_de != '0) && (s1_de != '1);
      if (vs_rise) begin
        if (state != ST_SEEK) begin
          if ((lines == L_FULL) && !frame_bad) done_n = 1'b1;
          else new_err[STAT_FRAME] = 1'b1;
        end
        state_n     = ST_BLANK;
        x_n         = '0;
        ovf_n       = '0;
        y_n         = '0;
        lines_n     = '0;
        frame_bad_n = 1'b0;
      end else begin
        case (state)
          ST_BLANK: begin
            if (de_rise) begin
              state_n = ST_LINE;
              x_n     = '0;
              ovf_n   = '0;
            end
          end
          ST_LINE: begin
            if (de_fall) begin
              state_n = ST_BLANK;
              if ((x_cnt != X_LAST) || (ovf_cnt != '0)) begin
                new_err[STAT_LINE] = 1'b1;
                frame_bad_n        = 1'b1;
              end
              if (y_cnt != Y_LAST) y_n = y_cnt + 1'b1;
              if (lines != L_MAX) lines_n = lines + 1'b1;
            end else if (s1_de[0]) begin
              if (x_cnt != X_LAST) x_n = x_cnt + 1'b1;
              else if (ovf_cnt != '1) ovf_n = ovf_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_SEEK;
      x_cnt      <= '0;
      ovf_cnt    <= '0;
      y_cnt      <= '0;
      lines      <= '0;
      frame_bad  <= 1'b0;
      pix_vld    <= 1'b0;
      pix_data   <= '0;
      pix_de     <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      sym_err    <= '0;
      frame_done <= 1'b0;
      status     <= '0;
    end else begin
      state      <= state_n;
      x_cnt      <= x_n;
      ovf_cnt    <= ovf_n;
      y_cnt      <= y_n;
      lines      <= lines_n;
      frame_bad  <= frame_bad_n;
      pix_vld    <= s1_vld;
      sym_err    <= s1_vld ? s1_err : '0;
      frame_done <= done_n;
      status     <= (err_clr ? 3'b000 : status) | new_err;
      if (s1_vld) begin
        pix_data <= s1_data;
        pix_de   <= s1_de[0];
        hsync    <= s1_c0;
        vsync    <= s1_c1;
      end
    end
  end

  assign pix_x = (state == ST_LINE) ? x_cnt : '0;
  assign pix_y = (state == ST_LINE) ? y_cnt : '0;

endmodule

// File: tb/tb_tmds_decoder_mc.sv
// Scoreboard bench for tmds_decoder_mc: TMDS-encoded random-gap traffic with
// expectations from a frame-level reference model, checked by a monitor.
module tb_tmds_decoder_mc;

  localparam int NCH = 3;
  localparam int H   = 256;
  localparam int V   = 16;
  localparam int XW  = $clog2(H);
  localparam int YW  = $clog2(V);

  logic              clk, rst, sym_vld, err_clr;
  logic [NCH*10-1:0] sym_in;
  logic [NCH*8-1:0]  pix_data;
  logic              pix_de, hsync, vsync, pix_vld, frame_done;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic [NCH-1:0]    sym_err;
  logic [2:0]        status;

  tmds_decoder_mc #(.NCH(NCH), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_vld(sym_vld), .err_clr(err_clr),
    .pix_data(pix_data), .pix_de(pix_de), .hsync(hsync), .vsync(vsync),
    .pix_vld(pix_vld), .pix_x(pix_x), .pix_y(pix_y), .sym_err(sym_err),
    .frame_done(frame_done), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0]   data;
    logic          de, hs, vs;
    logic [2:0]    serr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fd;
    logic [2:0]    st;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0, fd_seen = 0, last_x = -1, last_y = -1;
  logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  int rd [3] = '{0, 0, 0};

  // Reference model state, in frame terms rather than register terms.
  bit m_seek, m_inline, m_prev_vs, m_prev_de, m_bad;
  int m_pix, m_lines;
  logic [2:0] m_status;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == TOK[i]) return i;
    return -1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Standard DVI TMDS encoder with per-channel running disparity.
  function automatic logic [9:0] enc(input int ch, input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] s;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (rd[ch] == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8] == 1'b0) rd[ch] += n0q - n1q;
      else rd[ch] += n1q - n0q;
    end else if ((rd[ch] > 0 && n1q > n0q) || (rd[ch] < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      rd[ch] += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      rd[ch] += -2 * int'(~qm[8]) + n1q - n0q;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_seek = 1; m_inline = 0; m_prev_vs = 0; m_prev_de = 0; m_bad = 0;
    m_pix = 0; m_lines = 0; m_status = '0;
  endtask

  task automatic issue(input logic [29:0] s, input logic [23:0] bytes);
    exp_t e;
    logic [2:0] dev, nerr;
    logic [1:0] c;
    int ti, pc;
    while ($urandom_range(0, 7) == 0) begin
      @(negedge clk);
      sym_vld = 1'b0;
      sym_in  = 30'($urandom);
    end
    @(negedge clk);
    sym_in  = s;
    sym_vld = 1'b1;
    c = 2'b00;
    e.data = '0;
    e.serr = '0;
    for (int k = 0; k < NCH; k++) begin
      ti = tok_idx(s[10*k +: 10]);
      if (ti < 0) begin
        dev[k] = 1'b1;
        e.data[8*k +: 8] = bytes[8*k +: 8];
        pc = $countones(s[10*k +: 10]);
        e.serr[k] = (pc < 3) || (pc > 7);
      end else begin
        dev[k] = 1'b0;
        if (k == 0) c = 2'(ti);
      end
    end
    nerr = '0;
    e.fd = 1'b0;
    if (dev != 3'b000 && dev != 3'b111) nerr[0] = 1'b1;
    if (c[1] && !m_prev_vs) begin
      if (!m_seek) begin
        if (m_lines == V && !m_bad) e.fd = 1'b1;
        else nerr[2] = 1'b1;
      end
      m_seek = 0; m_inline = 0; m_lines = 0; m_bad = 0;
    end else if (!m_seek) begin
      if (!m_inline && dev[0] && !m_prev_de) begin
        m_inline = 1;
        m_pix = 0;
      end else if (m_inline && !dev[0] && m_prev_de) begin
        m_inline = 0;
        if (m_pix != H) begin
          nerr[1] = 1'b1;
          m_bad = 1;
        end
        m_lines++;
      end
    end
    if (m_inline && dev[0]) m_pix++;
    e.x = m_inline ? XW'(imin(m_pix - 1, H - 1)) : '0;
    e.y = m_inline ? YW'(imin(m_lines, V - 1)) : '0;
    m_status = m_status | nerr;
    e.st = m_status;
    e.de = dev[0];
    e.hs = c[0];
    e.vs = c[1];
    e.cyc = cyc;
    m_prev_vs = c[1];
    m_prev_de = dev[0];
    q.push_back(e);
  endtask

  task automatic blank(input int n, input logic hs, input logic vs);
    for (int i = 0; i < n; i++) issue({TOK[0], TOK[0], TOK[{vs, hs}]}, '0);
  endtask

  task automatic vsync_blk();
    blank(3, 1'b0, 1'b1);
    blank(2, 1'b0, 1'b0);
  endtask

  task automatic line(input int y, input int npix, input int tok_x);
    logic [7:0] r, g, b;
    logic [9:0] s2;
    for (int x = 0; x < npix; x++) begin
      b = 8'(x);
      g = 8'(x + y);
      r = 8'(x + 2 * y);
      if (x == tok_x) begin
        s2 = TOK[0];
        r  = 8'h00;
      end else begin
        s2 = enc(2, r);
      end
      issue({s2, enc(1, g), enc(0, b)}, {r, g, b});
    end
    blank(2, 1'b1, 1'b0);
    blank(2, 1'b0, 1'b0);
  endtask

  task automatic frame_lines(input int first, input int last, input int short_y, input int tok_y);
    for (int y = first; y <= last; y++)
      line(y, (y == short_y) ? H - 1 : H, (y == tok_y) ? 5 : -1);
  endtask

  task automatic drain();
    @(negedge clk);
    sym_vld = 1'b0;
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic clr();
    @(negedge clk);
    err_clr  = 1'b1;
    m_status = '0;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("status_clr", 64'(status), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({pix_data, pix_de, hsync, vsync, pix_vld, pix_x, pix_y, sym_err, frame_done, status}), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (pix_vld) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(pix_vld), 64'd0);
        end else begin
          e = q.pop_front();
          check("xfer", 64'({pix_data, pix_de, hsync, vsync, sym_err, pix_x, pix_y, frame_done, status}),
                64'({e.data, e.de, e.hs, e.vs, e.serr, e.x, e.y, e.fd, e.st}));
          check("latency", 64'(cyc - e.cyc), 64'd2);
          if (pix_de) begin
            last_x = int'(pix_x);
            last_y = int'(pix_y);
          end
          if (frame_done) fd_seen++;
        end
      end else begin
        check("idle_pulses", 64'({frame_done, sym_err}), 64'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; sym_vld = 1'b0; sym_in = '0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) issue({TOK[i], TOK[i], TOK[i]}, '0);
    blank(1, 1'b0, 1'b0);

    // Frame A: clean geometry; its opening vsync closes an empty frame.
    vsync_blk();
    frame_lines(0, V - 1, -1, -1);
    drain();
    check("last_pix_x", 64'(last_x), 64'(H - 1));
    check("last_pix_y", 64'(last_y), 64'(V - 1));
    clr();

    // Frame B: one short line.
    vsync_blk();
    frame_lines(0, V - 1, 3, -1);
    drain();
    check("status_short_line", 64'(status), 64'(3'b010));
    check("frame_done_count_B", 64'(fd_seen), 64'd1);

    // Frame C: channel disagreement on one pixel.
    vsync_blk();
    frame_lines(0, V - 1, -1, 2);
    drain();
    check("status_de_err", 64'(status), 64'(3'b111));
    check("frame_done_count_C", 64'(fd_seen), 64'd1);
    clr();

    // Frame D: reset half way through.
    vsync_blk();
    frame_lines(0, V / 2 - 1, -1, -1);
    drain();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    frame_lines(V / 2, V - 1, -1, -1);
    drain();
    check("status_after_reset", 64'(status), 64'd0);

    // Frame E: first full frame after reset.
    vsync_blk();
    frame_lines(0, V - 1, -1, -1);
    vsync_blk();
    drain();
    check("status_final", 64'(status), 64'd0);
    check("frame_done_total", 64'(fd_seen), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
